// File: rtl/tx_word_packer.sv
// tx_word_packer: 32-bit word stream to 9-bit {eof, byte} TX FIFO writes.
// Pads each frame's FIFO footprint to a multiple of four entries.
module tx_word_packer #(
    parameter logic [7:0] PAD_BYTE  = 8'h00,
    parameter int         MAX_STD   = 1500,
    parameter int         MAX_JUMBO = 9000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        jumboframes,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic [1:0]  in_bytes,
    output logic        in_ready,
    output logic [8:0]  txff_din,
    output logic        txff_wren,
    input  logic        txff_full,
    output logic [31:0] frame_count,
    output logic [15:0] ovf_count,
    output logic        busy
);

    typedef enum logic {
        FS_IDLE,
        FS_FRAME
    } fstate_t;

    localparam logic [13:0] LIM_STD   = 14'(MAX_STD);
    localparam logic [13:0] LIM_JUMBO = 14'(MAX_JUMBO);

    logic        hold_valid;
    logic [31:0] hold_data;
    logic        hold_last;
    logic [1:0]  last_idx;
    logic [1:0]  byte_idx;

    fstate_t     state;
    logic [13:0] byte_cnt;
    logic [13:0] limit;

    logic        wr;
    logic        wrap;
    logic        accept;
    logic        pad;
    logic        eof_pos;
    logic        eof_wr;
    logic        over;
    logic [13:0] new_limit;
    logic [7:0]  cur_byte;

    assign wr        = hold_valid & ~txff_full;
    assign wrap      = wr & (byte_idx == 2'd3);
    assign in_ready  = ~hold_valid | ((byte_idx == 2'd3) & ~txff_full);
    assign accept    = in_valid & in_ready;
    assign pad       = hold_last & (byte_idx > last_idx);
    assign eof_pos   = hold_last & (byte_idx == last_idx);
    assign eof_wr    = wr & eof_pos;
    assign over      = ({1'b0, byte_cnt} + 15'd1) > {1'b0, limit};
    assign new_limit = jumboframes ? LIM_JUMBO : LIM_STD;
    assign txff_wren = wr;
    assign busy      = (state == FS_FRAME);

    // Select the held byte at byte_idx, most significant byte first.
    always_comb begin
        cur_byte = hold_data[31:24];
        unique case (byte_idx)
            2'd0: cur_byte = hold_data[31:24];
            2'd1: cur_byte = hold_data[23:16];
            2'd2: cur_byte = hold_data[15:8];
            2'd3: cur_byte = hold_data[7:0];
        endcase
    end

    // Build the FIFO entry: data byte with eof flag, or an alignment pad.
    always_comb begin
        txff_din = '0;
        if (hold_valid) begin
            if (pad) begin
                txff_din = {1'b0, PAD_BYTE};
            end else begin
                txff_din = {eof_pos, cur_byte};
            end
        end
    end

    // Hold register: load on accept, step one byte per write, empty on wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_last  <= 1'b0;
            last_idx   <= '0;
            byte_idx   <= '0;
        end else begin
            if (wr) begin
                byte_idx <= byte_idx + 2'd1;
            end
            if (accept) begin
                hold_valid <= 1'b1;
                hold_data  <= in_data;
                hold_last  <= in_last;
                last_idx   <= in_bytes - 2'd1;
            end else if (wrap) begin
                hold_valid <= 1'b0;
            end
        end
    end

    // Frame FSM with byte counting, frame and oversize counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= FS_IDLE;
            byte_cnt    <= '0;
            limit       <= LIM_STD;
            frame_count <= '0;
            ovf_count   <= '0;
        end else begin
            if (eof_wr) begin
                frame_count <= frame_count + 32'd1;
                if (over && ovf_count != 16'hFFFF) begin
                    ovf_count <= ovf_count + 16'd1;
                end
            end
            if (wr && !pad && byte_cnt != 14'h3FFF) begin
                byte_cnt <= byte_cnt + 14'd1;
            end
            unique case (state)
                FS_IDLE: begin
                    if (accept) begin
                        state    <= FS_FRAME;
                        byte_cnt <= '0;
                        limit    <= new_limit;
                    end
                end
                FS_FRAME: begin
                    if (eof_wr) begin
                        if (accept) begin
                            byte_cnt <= '0;
                            limit    <= new_limit;
                        end else begin
                            state <= FS_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_word_packer.sv
// tb_tx_word_packer: directed checks of tx_word_packer.
// Inputs change 1 time unit after posedge, outputs sampled at negedge.
module tb_tx_word_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        jumboframes = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [1:0]  in_bytes = '0;
    logic        in_ready;
    logic [8:0]  txff_din;
    logic        txff_wren;
    logic        txff_full = 1'b0;
    logic [31:0] frame_count;
    logic [15:0] ovf_count;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc;
    int bad;
    logic [8:0] logd[$];
    int         logc[$];
    logic [8:0] exp_q[$];

    tx_word_packer dut (
        .clk(clk),
        .reset_n(reset_n),
        .jumboframes(jumboframes),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_bytes(in_bytes),
        .in_ready(in_ready),
        .txff_din(txff_din),
        .txff_wren(txff_wren),
        .txff_full(txff_full),
        .frame_count(frame_count),
        .ovf_count(ovf_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n && txff_wren) begin
            logd.push_back(txff_din);
            logc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic l,
                        input logic [1:0] b, output int a);
        in_data  = d;
        in_last  = l;
        in_bytes = b;
        in_valid = 1'b1;
        a = -1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                a = cyc;
                break;
            end
        end
        if (a < 0) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout: got no in_ready expected in_ready");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_log(input string tag, input logic [8:0] e[$]);
        chk({tag, "_count"}, 32'(logd.size()), 32'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            if (i < logd.size()) begin
                chk($sformatf("%s_w%0d", tag, i), 32'(logd[i]), 32'(e[i]));
            end
        end
    endtask

    task automatic send_frame(input int nw, input logic jf, input logic ja);
        jumboframes = jf;
        for (int w = 0; w < nw; w++) begin
            push({8'(4 * w), 8'(4 * w + 1), 8'(4 * w + 2), 8'(4 * w + 3)},
                 (w == nw - 1), 2'd0, acc);
            jumboframes = ja;
        end
    endtask

    task automatic check_frame(input string tag, input int nw);
        int n;
        n = nw * 4;
        bad = 0;
        for (int i = 0; i < logd.size(); i++) begin
            if (logd[i] !== {(i == n - 1), 8'(i)}) bad++;
        end
        chk({tag, "_count"}, 32'(logd.size()), 32'(n));
        chk({tag, "_data"}, 32'(bad), 32'd0);
    endtask

    initial begin
        // T1: reset state, then single full word
        @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_wren", 32'(txff_wren), 32'd0);
        chk("rst_din", 32'(txff_din), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frames", frame_count, 32'd0);
        chk("rst_ovf", 32'(ovf_count), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1);
        logd.delete();
        logc.delete();
        push(32'hAABBCCDD, 1'b1, 2'd0, acc);
        step(6);
        exp_q = '{9'h0AA, 9'h0BB, 9'h0CC, 9'h1DD};
        check_log("t1", exp_q);
        if (logc.size() == 4) begin
            chk("t1_latency", 32'(logc[0]), 32'(acc + 1));
            chk("t1_span", 32'(logc[3] - logc[0]), 32'd3);
        end
        chk("t1_frames", frame_count, 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);

        // T2: three-byte frame with one pad entry
        logd.delete();
        logc.delete();
        push(32'h11223344, 1'b1, 2'd3, acc);
        step(6);
        exp_q = '{9'h011, 9'h022, 9'h133, 9'h000};
        check_log("t2", exp_q);
        chk("t2_ovf", 32'(ovf_count), 32'd0);
        chk("t2_frames", frame_count, 32'd2);

        // T3: back-to-back frames of 8 and 5 bytes
        logd.delete();
        logc.delete();
        push(32'h01020304, 1'b0, 2'd0, acc);
        push(32'h05060708, 1'b1, 2'd0, acc);
        push(32'h090A0B0C, 1'b0, 2'd0, acc);
        push(32'h0D000000, 1'b1, 2'd1, acc);
        step(8);
        exp_q = '{9'h001, 9'h002, 9'h003, 9'h004,
                  9'h005, 9'h006, 9'h007, 9'h108,
                  9'h009, 9'h00A, 9'h00B, 9'h00C,
                  9'h10D, 9'h000, 9'h000, 9'h000};
        check_log("t3", exp_q);
        if (logc.size() == 16) begin
            chk("t3_span", 32'(logc[15] - logc[0]), 32'd15);
        end
        chk("t3_frames", frame_count, 32'd4);

        // T4: FIFO full for three cycles after the first byte
        logd.delete();
        logc.delete();
        push(32'h55667788, 1'b1, 2'd0, acc);
        @(posedge clk);
        #1;
        txff_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t4_wren%0d", k), 32'(txff_wren), 32'd0);
            chk($sformatf("t4_ready%0d", k), 32'(in_ready), 32'd0);
            chk($sformatf("t4_busy%0d", k), 32'(busy), 32'd1);
            @(posedge clk);
            #1;
        end
        txff_full = 1'b0;
        step(6);
        exp_q = '{9'h055, 9'h066, 9'h077, 9'h188};
        check_log("t4", exp_q);
        if (logc.size() == 4) begin
            chk("t4_gap", 32'(logc[1] - logc[0]), 32'd4);
        end
        chk("t4_frames", frame_count, 32'd5);

        // T5: oversize detection and limit latching
        logd.delete();
        logc.delete();
        send_frame(376, 1'b0, 1'b0);
        step(6);
        check_frame("t5a", 376);
        chk("t5a_ovf", 32'(ovf_count), 32'd1);
        logd.delete();
        logc.delete();
        send_frame(376, 1'b1, 1'b0);
        step(6);
        check_frame("t5b", 376);
        chk("t5b_ovf", 32'(ovf_count), 32'd1);
        logd.delete();
        logc.delete();
        send_frame(375, 1'b0, 1'b0);
        step(6);
        check_frame("t5c", 375);
        chk("t5c_ovf", 32'(ovf_count), 32'd1);
        chk("t5_frames", frame_count, 32'd8);

        // T6: reset after two bytes of a word
        push(32'hDEADBEEF, 1'b0, 2'd0, acc);
        step(1);
        @(negedge clk);
        chk("t6_busy_pre", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_wren", 32'(txff_wren), 32'd0);
        chk("t6_ready", 32'(in_ready), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_frames", frame_count, 32'd0);
        chk("t6_ovf", 32'(ovf_count), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        logd.delete();
        logc.delete();
        push(32'h01020304, 1'b1, 2'd2, acc);
        step(6);
        exp_q = '{9'h001, 9'h102, 9'h000, 9'h000};
        check_log("t6_post", exp_q);
        chk("t6_post_frames", frame_count, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
